// File: rtl/dec_64_b.sv
// 6-bit index to 64-bit one-hot decoder gated by a valid strobe.
// OUT_REG selects a one-cycle registered output or a purely combinational one.
module dec_64_b #(
    parameter logic OUT_REG = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic [5:0]  data_i,
    output logic        done_o,
    output logic [63:0] data_o
);

    logic [63:0] dec_w;
    logic        vld_w;

    always_comb begin
        dec_w = 64'b0;
        if (init_i) begin
            dec_w = 64'd1 << data_i;
        end
        vld_w = init_i;
    end

    generate
        if (OUT_REG) begin : g_reg
            logic [63:0] data_q, data_d;
            logic        done_q, done_d;

            always_comb begin
                data_d = dec_w;
                done_d = vld_w;
            end

            // Reset wins over a concurrent valid input.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    data_q <= 64'b0;
                    done_q <= 1'b0;
                end else begin
                    data_q <= data_d;
                    done_q <= done_d;
                end
            end

            assign data_o = data_q;
            assign done_o = done_q;
        end else begin : g_comb
            logic unused_clk_w;
            assign unused_clk_w = clk_i;

            assign data_o = rst_i ? 64'b0 : dec_w;
            assign done_o = rst_i ? 1'b0  : vld_w;
        end
    endgenerate

endmodule

// File: tb/tb_dec_64_b.sv
// Self-checking bench for dec_64_b: registered and combinational instances
// driven in parallel, compared against a bit-position reference model.
module tb_dec_64_b;

    logic        clk;
    logic        rst;
    logic        init;
    logic [5:0]  din;
    logic        done_r, done_c;
    logic [63:0] dout_r, dout_c;

    int n_vec = 0;
    int n_err = 0;

    dec_64_b #(.OUT_REG(1'b1)) u_dut_reg (
        .clk_i  (clk),
        .rst_i  (rst),
        .init_i (init),
        .data_i (din),
        .done_o (done_r),
        .data_o (dout_r)
    );

    dec_64_b #(.OUT_REG(1'b0)) u_dut_comb (
        .clk_i  (clk),
        .rst_i  (rst),
        .init_i (init),
        .data_i (din),
        .done_o (done_c),
        .data_o (dout_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the word has exactly the bit whose position equals the index.
    function automatic logic [63:0] ref_word(input bit r, input bit v, input int idx);
        logic [63:0] w;
        w = '0;
        if (!r && v) begin
            for (int i = 0; i < 64; i++) begin
                w[i] = (i == idx);
            end
        end
        return w;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    // Inputs are applied 1ns after a rising edge; the combinational instance is
    // checked before the next edge, the registered one 1ns after it.
    task automatic cycle(input bit r, input bit v, input logic [5:0] d);
        logic [63:0] e;
        rst  = r;
        init = v;
        din  = d;
        e = ref_word(r, v, int'(d));
        #1;
        check_val("comb_data", dout_c, e);
        check_val("comb_done", {63'b0, done_c}, {63'b0, (!r && v)});
        @(posedge clk);
        #1;
        check_val("reg_data", dout_r, e);
        check_val("reg_done", {63'b0, done_r}, {63'b0, (!r && v)});
        if (!r && v) begin
            check_val("reg_onehot", 64'($countones(dout_r)), 64'd1);
        end
    endtask

    initial begin
        rst  = 1'b1;
        init = 1'b1;
        din  = 6'd9;
        @(posedge clk);
        #1;

        // Reset held with a valid input present
        cycle(1'b1, 1'b1, 6'd9);
        cycle(1'b1, 1'b1, 6'd9);
        check_val("rst_data_const", dout_r, 64'h0);

        // Full sweep
        for (int k = 0; k < 64; k++) begin
            cycle(1'b0, 1'b1, 6'(k));
        end
        check_val("sweep_63", dout_r, 64'h8000_0000_0000_0000);

        // Valid drop and idle
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 6'd63);
            check_val("idle_data", dout_r, 64'h0);
        end

        // Combinational spot values
        cycle(1'b0, 1'b1, 6'd0);
        check_val("comb_0", dout_c, 64'h1);
        cycle(1'b0, 1'b1, 6'd37);
        check_val("comb_37", dout_c, 64'h20_0000_0000);
        cycle(1'b0, 1'b1, 6'd63);
        check_val("comb_63", dout_c, 64'h8000_0000_0000_0000);

        // Mid-stream reset
        cycle(1'b0, 1'b1, 6'd10);
        check_val("mid_10", dout_r, 64'h400);
        cycle(1'b1, 1'b1, 6'd11);
        check_val("mid_rst", dout_r, 64'h0);
        check_val("mid_rst_done", {63'b0, done_r}, 64'h0);
        cycle(1'b0, 1'b1, 6'd12);
        check_val("mid_12", dout_r, 64'h1000);

        // Random traffic with occasional reset
        for (int k = 0; k < 1000; k++) begin
            cycle(($urandom_range(0, 15) == 0), 1'($urandom), 6'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
